// File: rtl/pwm_capture.sv
// pwm_capture: measures an external PWM waveform in CLK cycles.
// Publishes high time (Count_D), period (Count_P) and floor(Count_D*100/Count_P)
// via a restoring divider that produces one quotient bit per cycle.
// A static input (no rising edge for TIMEOUT cycles) publishes period 0 with
// duty 100 or 0 according to the held level.
module pwm_capture #(
    parameter logic [23:0] TIMEOUT  = 24'd12_000_000,
    parameter int          DIV_BITS = 31
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        PWM_In,
    output logic [23:0] Count_D,
    output logic [23:0] Count_P,
    output logic [7:0]  Duty,
    output logic        Duty_Valid,
    output logic        Busy
);

    typedef enum logic {
        S_WAIT,
        S_RUN
    } state_t;

    localparam int               CNT_W   = $clog2(DIV_BITS + 1);
    localparam logic [CNT_W-1:0] ITERS   = CNT_W'(DIV_BITS);
    localparam logic [23:0]      CNT_MAX = 24'hFFFFFF;

    // Input conditioning
    logic sync1_q, sync2_q, sync_dly_q;
    logic rise, level;

    // Measurement counters
    logic [23:0] per_cnt_q, per_cnt_d;
    logic [23:0] hi_cnt_q, hi_cnt_d;

    // Measurement FSM
    state_t state_q, state_d;
    logic   timeout_hit, capture, timeout_pub;

    // Divider
    logic                div_busy_q;
    logic [CNT_W-1:0]    div_cnt_q;
    logic [23:0]         div_rem_q, div_rem_d;
    logic [23:0]         div_den_q;
    logic [DIV_BITS-1:0] div_quo_q, div_quo_d;
    logic [DIV_BITS-1:0] dividend;
    logic [24:0]         rem_shift;
    logic                rem_ge;
    logic                div_last;

    // Published results
    logic [23:0] count_d_q, count_p_q;
    logic [7:0]  duty_q;
    logic        valid_q;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync_dly_q <= 1'b0;
        end else begin
            sync1_q    <= PWM_In;
            sync2_q    <= sync1_q;
            sync_dly_q <= sync2_q;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~sync_dly_q;

    // Counter next-state: restart at 1 on a rise, otherwise count up and saturate.
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise) begin
            per_cnt_d = 24'd1;
            hi_cnt_d  = 24'd1;
        end else begin
            if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + 24'd1;
            if (level && (hi_cnt_q != CNT_MAX)) hi_cnt_d = hi_cnt_q + 24'd1;
        end
    end

    // Period and high-time counter registers.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            per_cnt_q <= 24'd0;
            hi_cnt_q  <= 24'd0;
        end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
        end
    end

    assign timeout_hit = (per_cnt_q == TIMEOUT);

    // Measurement FSM next state: a rise always wins over a coincident timeout.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        timeout_pub = 1'b0;
        case (state_q)
            S_WAIT: begin
                // The period ending at the first edge is partial, so it is never published.
                if (rise) begin
                    state_d = S_RUN;
                end else if (timeout_hit) begin
                    timeout_pub = 1'b1;
                end
            end
            S_RUN: begin
                if (rise) begin
                    // A rise while the divider is busy only restarts the counters.
                    capture = ~div_busy_q;
                end else if (timeout_hit) begin
                    timeout_pub = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Measurement FSM state register.
    always_ff @(posedge CLK) begin
        if (Rst) state_q <= S_WAIT;
        else     state_q <= state_d;
    end

    // One restoring-division step: shift the next dividend bit into the remainder.
    assign dividend  = DIV_BITS'(hi_cnt_q) * DIV_BITS'(7'd100);
    assign rem_shift = {div_rem_q, div_quo_q[DIV_BITS-1]};
    assign rem_ge    = (rem_shift >= {1'b0, div_den_q});
    // When rem_ge holds the true difference is below the divisor, so 24 bits suffice.
    assign div_rem_d = rem_ge ? (rem_shift[23:0] - div_den_q) : rem_shift[23:0];
    assign div_quo_d = {div_quo_q[DIV_BITS-2:0], rem_ge};
    assign div_last  = div_busy_q && (div_cnt_q == CNT_W'(1));

    // Divider control: load on capture, iterate while busy, abort on timeout.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            div_busy_q <= 1'b0;
            div_cnt_q  <= '0;
            div_rem_q  <= 24'd0;
            div_den_q  <= 24'd0;
            div_quo_q  <= '0;
        end else if (timeout_pub) begin
            div_busy_q <= 1'b0;
        end else if (capture) begin
            div_busy_q <= 1'b1;
            div_cnt_q  <= ITERS;
            div_rem_q  <= 24'd0;
            div_den_q  <= per_cnt_q;
            div_quo_q  <= dividend;
        end else if (div_busy_q) begin
            div_rem_q <= div_rem_d;
            div_quo_q <= div_quo_d;
            div_cnt_q <= div_cnt_q - CNT_W'(1);
            if (div_last) div_busy_q <= 1'b0;
        end
    end

    // Published outputs: counts at capture, duty when the divider finishes, or a timeout set.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            count_d_q <= 24'd0;
            count_p_q <= 24'd0;
            duty_q    <= 8'd0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (timeout_pub) begin
                count_d_q <= 24'd0;
                count_p_q <= 24'd0;
                duty_q    <= level ? 8'd100 : 8'd0;
                valid_q   <= 1'b1;
            end else begin
                if (capture) begin
                    count_p_q <= per_cnt_q;
                    count_d_q <= hi_cnt_q;
                end
                // Count_D <= Count_P, so the quotient is at most 100 and fits 8 bits.
                if (div_last) begin
                    duty_q  <= div_quo_d[7:0];
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign Count_D    = count_d_q;
    assign Count_P    = count_p_q;
    assign Duty       = duty_q;
    assign Duty_Valid = valid_q;
    assign Busy       = div_busy_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: directed phases plus random waveforms, every cycle
// compared against an event-level reference model (rise timestamps, running
// high-cycle totals, and integer division for the duty value).
module tb_pwm_capture;

    localparam int TO = 1500;

    logic        CLK;
    logic        Rst;
    logic        PWM_In;
    logic [23:0] Count_D;
    logic [23:0] Count_P;
    logic [7:0]  Duty;
    logic        Duty_Valid;
    logic        Busy;

    pwm_capture #(
        .TIMEOUT (24'(TO)),
        .DIV_BITS(31)
    ) dut (
        .CLK       (CLK),
        .Rst       (Rst),
        .PWM_In    (PWM_In),
        .Count_D   (Count_D),
        .Count_P   (Count_P),
        .Duty      (Duty),
        .Duty_Valid(Duty_Valid),
        .Busy      (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;
    int n_valid = 0;

    // ---------------- Reference model ----------------
    // The design sees the pin two cycles late; pin_q holds the last three raw samples.
    bit          pin_q[$];
    bit          m_live = 0;
    bit          m_run, m_pend;
    int unsigned m_cyc, m_anchor, m_high_total, m_high_at_anchor, m_done, m_duty;
    logic [23:0] e_cd, e_cp;
    logic [7:0]  e_duty;
    logic        e_valid, e_busy;

    // Event-level model evaluated once per clock edge.
    always @(posedge CLK) begin
        bit          lvl, rise;
        int unsigned per, hi;
        if (Rst) begin
            m_live = 1; m_run = 0; m_pend = 0;
            e_cd = '0; e_cp = '0; e_duty = '0; e_valid = 0; e_busy = 0;
            pin_q = '{0, 0, 0};
            m_cyc = 0; m_anchor = 0; m_high_total = 0; m_high_at_anchor = 0;
        end else if (m_live) begin
            lvl  = pin_q[1];
            rise = pin_q[1] & ~pin_q[2];
            per  = m_cyc - m_anchor;
            hi   = m_high_total - m_high_at_anchor;
            e_valid = 0;
            if (rise) begin
                if (m_run && !m_pend) begin
                    e_cp   = 24'(per);
                    e_cd   = 24'(hi);
                    m_duty = (hi * 100) / per;
                    m_pend = 1;
                    m_done = m_cyc + 32;
                end
                m_run = 1;
                m_anchor = m_cyc;
                m_high_at_anchor = m_high_total;
            end else if (per == TO) begin
                m_pend  = 0;
                m_run   = 0;
                e_cp    = '0;
                e_cd    = '0;
                e_duty  = lvl ? 8'd100 : 8'd0;
                e_valid = 1;
            end
            if (lvl) m_high_total++;
            if (m_pend && (m_cyc + 1 == m_done)) begin
                e_duty  = 8'(m_duty);
                e_valid = 1;
                m_pend  = 0;
            end
            e_busy = m_pend;
            pin_q.push_front(PWM_In);
            void'(pin_q.pop_back());
            m_cyc++;
        end
    end

    // ---------------- Checking and stimulus helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the previous edge's outputs, then drive the pin for the next edge.
    task automatic tick(input bit pin);
        @(negedge CLK);
        if (m_live) begin
            check("cycle", {6'b0, Count_D, Count_P, Duty, Duty_Valid, Busy},
                           {6'b0, e_cd, e_cp, e_duty, e_valid, e_busy});
            if (Duty_Valid) n_valid++;
        end
        PWM_In = pin;
    endtask

    task automatic hold(input bit lvl, input int cycles);
        repeat (cycles) tick(lvl);
    endtask

    task automatic wave(input int period, input int high, input int n);
        for (int p = 0; p < n; p++)
            for (int c = 0; c < period; c++)
                tick(c < high);
    endtask

    task automatic check_set(input string tag, input int cp, input int cd, input int duty);
        check({tag, "_count_p"}, 64'(Count_P), 64'(cp));
        check({tag, "_count_d"}, 64'(Count_D), 64'(cd));
        check({tag, "_duty"},    64'(Duty),    64'(duty));
    endtask

    // ---------------- Directed and random sequence ----------------
    initial begin
        int v0;
        int per, hi, n;
        Rst    = 1'b1;
        PWM_In = 1'b0;
        hold(0, 3);
        check_set("reset", 0, 0, 0);
        check("reset_busy", 64'(Busy), 64'd0);
        Rst = 1'b0;

        // Static low input: nothing until the timeout, then exactly one pulse with duty 0.
        hold(0, TO - 10);
        check("idle_no_early_valid", 64'(n_valid), 64'd0);
        hold(0, 20);
        check("idle_timeout_pulses", 64'(n_valid), 64'd1);
        check_set("idle_timeout", 0, 0, 0);

        // 1000/500 square wave: first edge unpublished, three captures follow.
        v0 = n_valid;
        wave(1000, 500, 4);
        check_set("sq1000", 1000, 500, 50);
        check("sq1000_pulses", 64'(n_valid - v0), 64'd3);

        // 300/100: floor(10000/300) = 33.
        wave(300, 100, 3);
        check_set("p300", 300, 100, 33);

        // 7/6: only every fifth rise finds the divider idle.
        v0 = n_valid;
        wave(7, 6, 23);
        check_set("p7", 7, 6, 85);
        check("p7_pulses", 64'(n_valid - v0), 64'd4);
        check("p7_busy", 64'(Busy), 64'd1);

        // Held high: pending division completes, then timeout publishes duty 100.
        v0 = n_valid;
        hold(1, TO + 40);
        check_set("hold_hi", 0, 0, 100);
        check("hold_hi_pulses", 64'(n_valid - v0), 64'd2);

        // Random waveform then held low: timeout publishes duty 0.
        for (int i = 0; i < 3; i++) begin
            per = int'($urandom_range(400, 40));
            hi  = int'($urandom_range(per - 1, 1));
            n   = int'($urandom_range(4, 2));
            wave(per, hi, n);
        end
        hold(0, TO + 40);
        check_set("hold_lo", 0, 0, 0);

        // First edge after a timeout is not published.
        v0 = n_valid;
        wave(200, 50, 1);
        check("rewait_count_p", 64'(Count_P), 64'd0);
        check("rewait_pulses", 64'(n_valid - v0), 64'd0);

        // Reset in the middle of a division.
        wave(500, 200, 1);
        hold(1, 12);
        check("abort_busy_before", 64'(Busy), 64'd1);
        Rst = 1'b1;
        tick(0);
        Rst = 1'b0;
        check_set("abort", 0, 0, 0);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_valid", 64'(Duty_Valid), 64'd0);
        v0 = n_valid;
        hold(0, 5);
        wave(400, 100, 1);
        check("abort_first_edge", 64'(Count_P), 64'd0);
        check("abort_first_pulses", 64'(n_valid - v0), 64'd0);
        wave(400, 100, 2);
        check_set("after_abort", 400, 100, 25);

        // Fastest toggle.
        wave(2, 1, 60);
        check_set("p2", 2, 1, 50);

        // Random waveforms against the model.
        for (int i = 0; i < 8; i++) begin
            per = int'($urandom_range(600, 2));
            hi  = int'($urandom_range(per - 1, 1));
            n   = int'($urandom_range(3, 1));
            wave(per, hi, n);
        end
        hold(0, 50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
